// File: rtl/seg7_scan_decoder.sv
// Receive side of the 2-digit multiplexed 7-segment scan: watches AN/SEG and rebuilds the two
// BCD digits being displayed, flagging anode-protocol violations and non-decimal patterns.
module seg7_scan_decoder #(
    parameter int unsigned SETTLE = 16
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic [1:0] AN,
    input  logic [6:0] SEG,
    output logic [7:0] out,
    output logic       valid,
    output logic       upd,
    output logic       err
);

    // state      | meaning
    // ST_IDLE    | no digit driven (AN=11) or illegal AN=00
    // ST_SETTLE  | digit selected, waiting for SETTLE stable cycles
    // ST_CAPTURE | stable long enough; capture from the previous-sample register
    // ST_HOLD    | digit captured, waiting for the next input change
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_HOLD
    } state_t;

    localparam logic [15:0] SETTLE_C  = 16'(SETTLE);
    localparam logic [15:0] SETTLE_M1 = 16'(SETTLE - 1);

    logic [1:0]  an_s1_q, an_s2_q, an_p_q;
    logic [6:0]  seg_s1_q, seg_s2_q, seg_p_q;
    logic [15:0] cnt_q, cnt_d;
    state_t      state_q, state_d;
    logic [7:0]  out_q, out_d;
    logic        upd_q, upd_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [1:0]  seen_q, seen_d;

    logic        change;
    logic        capture;
    logic        err_set;
    logic [4:0]  dec;

    // Returns {bad, nibble}; blank is a legal "digit off" and reads as F.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b0000001: r = {1'b0, 4'h0};
            7'b1001111: r = {1'b0, 4'h1};
            7'b0010010: r = {1'b0, 4'h2};
            7'b0000110: r = {1'b0, 4'h3};
            7'b1001100: r = {1'b0, 4'h4};
            7'b0100100: r = {1'b0, 4'h5};
            7'b0100000: r = {1'b0, 4'h6};
            7'b0001111: r = {1'b0, 4'h7};
            7'b0000000: r = {1'b0, 4'h8};
            7'b0001100: r = {1'b0, 4'h9};
            7'b1111111: r = {1'b0, 4'hF};
            default:    r = {1'b1, 4'hE};
        endcase
        return r;
    endfunction

    assign change = {an_s2_q, seg_s2_q} != {an_p_q, seg_p_q};
    assign dec    = decode(seg_p_q);

    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        capture = 1'b0;
        if (change) begin
            cnt_d = 16'd0;
        end else if (cnt_q != SETTLE_C) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (an_s2_q == 2'b10 || an_s2_q == 2'b01) begin
                    state_d = ST_SETTLE;
                    cnt_d   = 16'd0;
                end else if (an_s2_q == 2'b00) begin
                    err_set = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!change && cnt_q == SETTLE_M1) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                capture = 1'b1;
                state_d = ST_HOLD;
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase

        // Any change outside IDLE restarts the dwell, or drops back to IDLE when no digit is selected.
        if (state_q != ST_IDLE && change) begin
            cnt_d = 16'd0;
            case (an_s2_q)
                2'b10, 2'b01: state_d = ST_SETTLE;
                2'b00: begin
                    state_d = ST_IDLE;
                    err_set = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        out_d  = out_q;
        upd_d  = 1'b0;
        seen_d = seen_q;
        err_d  = err_q | err_set;
        if (capture) begin
            upd_d = 1'b1;
            if (dec[4]) begin
                err_d = 1'b1;
            end
            if (an_p_q == 2'b10) begin
                out_d[3:0] = dec[3:0];
                seen_d[0]  = 1'b1;
            end else begin
                out_d[7:4] = dec[3:0];
                seen_d[1]  = 1'b1;
            end
        end
        valid_d = valid_q | (seen_d[0] & seen_d[1]);
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            an_s1_q  <= 2'b11;
            an_s2_q  <= 2'b11;
            an_p_q   <= 2'b11;
            seg_s1_q <= 7'h7F;
            seg_s2_q <= 7'h7F;
            seg_p_q  <= 7'h7F;
            cnt_q    <= 16'd0;
            state_q  <= ST_IDLE;
            out_q    <= 8'h00;
            upd_q    <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            seen_q   <= 2'b00;
        end else begin
            an_s1_q  <= AN;
            an_s2_q  <= an_s1_q;
            an_p_q   <= an_s2_q;
            seg_s1_q <= SEG;
            seg_s2_q <= seg_s1_q;
            seg_p_q  <= seg_s2_q;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            out_q    <= out_d;
            upd_q    <= upd_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            seen_q   <= seen_d;
        end
    end

    assign out   = out_q;
    assign upd   = upd_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: scan latency, glitch rejection, decode table,
// protocol errors and reset behaviour, with hand-computed expectations.
module tb_seg7_scan_decoder;

    localparam int SETTLE = 16;
    localparam int LAT    = 20;   // steps from driving an input to seeing upd (SETTLE+4)

    logic       CLK = 1'b0;
    logic       rst_n;
    logic [1:0] AN;
    logic [6:0] SEG;
    logic [7:0] out;
    logic       valid;
    logic       upd;
    logic       err;

    int checks = 0;
    int errors = 0;

    seg7_scan_decoder #(.SETTLE(SETTLE)) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .AN    (AN),
        .SEG   (SEG),
        .out   (out),
        .valid (valid),
        .upd   (upd),
        .err   (err)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Hold one AN/SEG pair for n cycles, reporting how many upd pulses and the step of the first.
    task automatic dwell(input logic [1:0] an, input logic [6:0] seg, input int n,
                         output int n_upd, output int first_upd);
        AN = an;
        SEG = seg;
        n_upd = 0;
        first_upd = 0;
        for (int k = 1; k <= n; k++) begin
            step();
            if (upd === 1'b1) begin
                n_upd++;
                if (first_upd == 0) first_upd = k;
            end
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        AN = 2'b11;
        SEG = 7'h7F;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        AN = 2'b00;
        SEG = 7'h55;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({out, valid, upd, err} !== 11'h000) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: out=%h valid=%b upd=%b err=%b expected 00/0/0/0",
                         i, out, valid, upd, err);
            end
        end
        rst_n = 1'b1;
        AN = 2'b11;
        SEG = 7'h7F;
        step();
        checks++;
        if ({out, valid, upd, err} !== 11'h000) begin
            errors++;
            $display("FAIL reset_release: out=%h valid=%b upd=%b err=%b expected 00/0/0/0",
                     out, valid, upd, err);
        end
    endtask

    task automatic test_scan_42();
        int n, f;
        dwell(2'b10, 7'b0010010, 64, n, f);
        checks++;
        if (f != LAT || n != 1) begin
            errors++;
            $display("FAIL scan_low_latency: first=%0d count=%0d expected first=%0d count=1", f, n, LAT);
        end
        checks++;
        if (out !== 8'h02 || valid !== 1'b0) begin
            errors++;
            $display("FAIL scan_low_value: out=%h valid=%b expected 02/0", out, valid);
        end
        dwell(2'b01, 7'b1001100, 64, n, f);
        checks++;
        if (f != LAT || n != 1) begin
            errors++;
            $display("FAIL scan_high_latency: first=%0d count=%0d expected first=%0d count=1", f, n, LAT);
        end
        checks++;
        if (out !== 8'h42 || valid !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL scan_42: out=%h valid=%b err=%b expected 42/1/0", out, valid, err);
        end
        dwell(2'b10, 7'b0010010, 64, n, f);
        checks++;
        if (n != 1 || out !== 8'h42 || valid !== 1'b1) begin
            errors++;
            $display("FAIL scan_repeat: count=%0d out=%h valid=%b expected 1/42/1", n, out, valid);
        end
    endtask

    task automatic test_glitch();
        int n, f;
        dwell(2'b10, 7'b0000000, 10, n, f);
        checks++;
        if (n != 0 || out !== 8'h42) begin
            errors++;
            $display("FAIL glitch_window: count=%0d out=%h expected 0/42", n, out);
        end
        dwell(2'b10, 7'b0010010, LAT - 1, n, f);
        checks++;
        if (n != 0 || out !== 8'h42) begin
            errors++;
            $display("FAIL glitch_return: count=%0d out=%h expected 0/42", n, out);
        end
        dwell(2'b10, 7'b0010010, 5, n, f);
        checks++;
        if (n != 1 || f != 1 || out !== 8'h42) begin
            errors++;
            $display("FAIL glitch_resettle: count=%0d first=%0d out=%h expected 1/1/42", n, f, out);
        end
    endtask

    task automatic test_no_digit();
        int n, f;
        logic [6:0] pats [3];
        pats[0] = 7'b0000000;
        pats[1] = 7'b1010101;
        pats[2] = 7'b1111111;
        for (int i = 0; i < 3; i++) begin
            dwell(2'b11, pats[i], 30, n, f);
            checks++;
            if (n != 0 || err !== 1'b0 || out !== 8'h42) begin
                errors++;
                $display("FAIL an11_seg%b: count=%0d err=%b out=%h expected 0/0/42", pats[i], n, err, out);
            end
        end
    endtask

    task automatic test_digit_table();
        int n, f;
        logic [6:0] tbl [10];
        tbl[0] = 7'b0000001; tbl[1] = 7'b1001111; tbl[2] = 7'b0010010; tbl[3] = 7'b0000110;
        tbl[4] = 7'b1001100; tbl[5] = 7'b0100100; tbl[6] = 7'b0100000; tbl[7] = 7'b0001111;
        tbl[8] = 7'b0000000; tbl[9] = 7'b0001100;
        for (int d = 0; d < 10; d++) begin
            dwell(2'b10, tbl[d], 24, n, f);
            checks++;
            if (n != 1 || out !== {4'h4, 4'(d)} || err !== 1'b0) begin
                errors++;
                $display("FAIL digit_%0d: count=%0d out=%h err=%b expected 1/4%0d/0", d, n, out, err, d);
            end
        end
        dwell(2'b10, 7'b1111111, 24, n, f);
        checks++;
        if (n != 1 || out !== 8'h4F || err !== 1'b0) begin
            errors++;
            $display("FAIL digit_blank: count=%0d out=%h err=%b expected 1/4f/0", n, out, err);
        end
    endtask

    task automatic test_an00();
        int n, f;
        dwell(2'b00, 7'b0000001, 40, n, f);
        checks++;
        if (n != 0 || err !== 1'b1 || out !== 8'h4F) begin
            errors++;
            $display("FAIL an00: count=%0d err=%b out=%h expected 0/1/4f", n, err, out);
        end
    endtask

    task automatic test_invalid();
        int n, f;
        pulse_reset();
        step();
        dwell(2'b01, 7'b1010101, 40, n, f);
        checks++;
        if (n != 1 || f != LAT || out !== 8'hE0 || err !== 1'b1) begin
            errors++;
            $display("FAIL invalid_pattern: count=%0d first=%0d out=%h err=%b expected 1/%0d/e0/1",
                     n, f, LAT, out, err);
        end
        dwell(2'b01, 7'b0001111, 40, n, f);
        checks++;
        if (n != 1 || out !== 8'h70 || err !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL after_invalid: count=%0d out=%h err=%b valid=%b expected 1/70/1/0",
                     n, out, err, valid);
        end
    endtask

    task automatic test_reset_mid_settle();
        int n, f;
        pulse_reset();
        step();
        dwell(2'b10, 7'b1001111, 10, n, f);
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL mid_settle_pre: count=%0d expected 0", n);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if ({out, valid, upd, err} !== 11'h000) begin
            errors++;
            $display("FAIL mid_settle_reset: out=%h valid=%b upd=%b err=%b expected 00/0/0/0",
                     out, valid, upd, err);
        end
        dwell(2'b10, 7'b1001111, 30, n, f);
        checks++;
        if (n != 1 || f != LAT || out !== 8'h01 || valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL mid_settle_capture: count=%0d first=%0d out=%h valid=%b err=%b expected 1/%0d/01/0/0",
                     n, f, out, valid, err, LAT);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        AN = 2'b11;
        SEG = 7'h7F;
        test_reset();
        test_scan_42();
        test_glitch();
        test_no_digit();
        test_digit_table();
        test_an00();
        test_invalid();
        test_reset_mid_settle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
